// File: rtl/ula_pkg.sv
// ula_pkg: shared ALU control codes, function fields and MDU state type.
package ula_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  localparam logic [1:0] UOP_LS   = 2'b00;
  localparam logic [1:0] UOP_BR   = 2'b01;
  localparam logic [1:0] UOP_R    = 2'b10;
  localparam logic [1:0] UOP_ADDI = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} mdu_state_e;

  function automatic logic is_mdu_func(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
  endfunction
endpackage

// File: rtl/ula_mdu.sv
// ula_mdu: iterative shift-add multiplier / restoring divider, one bit per cycle,
// with sign handling on magnitudes and results presented during FIN.
module ula_mdu
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, acc_q, acc_d;
  logic sgn_q, sgn_d, div_q, div_d;
  logic [WIDTH:0] sum, shifted, diff;
  logic [2*WIDTH:0] mul_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  logic last;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    sum     = {1'b0, acc_q} + (x_q[0] ? {1'b0, y_q} : '0);
    mul_sh  = {sum, x_q} >> 1;
    shifted = {acc_q, x_q[WIDTH-1]};
    diff    = shifted - {1'b0, y_q};
    last    = cnt_q == CW'(WIDTH - 1);
    // x holds multiplier/dividend magnitude, y multiplicand/divisor magnitude
    if (state_q == ST_IDLE && (start_mul || start_div)) begin
      state_d = start_div ? ST_DIV : ST_MUL;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      x_d     = (is_signed && a[WIDTH-1]) ? -a : a;
      y_d     = (is_signed && b[WIDTH-1]) ? -b : b;
      acc_d   = '0;
      sgn_d   = is_signed;
      div_d   = start_div;
    end else if (state_q == ST_MUL) begin
      acc_d   = mul_sh[2*WIDTH-1:WIDTH];
      x_d     = mul_sh[WIDTH-1:0];
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? ST_FIN : ST_MUL;
    end else if (state_q == ST_DIV) begin
      acc_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      x_d     = {x_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? ST_FIN : ST_DIV;
    end else if (state_q == ST_FIN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end
  always_comb begin
    prod   = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -{acc_q, x_q} : {acc_q, x_q};
    quo    = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -x_q : x_q;
    rem    = (sgn_q && a_q[WIDTH-1]) ? -acc_q : acc_q;
    hi_res = !div_q ? prod[2*WIDTH-1:WIDTH] : (b_q == '0) ? a_q : rem;
    lo_res = !div_q ? prod[WIDTH-1:0] : (b_q == '0) ? '1 : quo;
    busy   = state_q != ST_IDLE;
    done   = state_q == ST_FIN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
    end
  end
endmodule

// File: rtl/ula_control_md.sv
// ula_control_md: ALU control decode plus HI/LO registers fed by the
// iterative multiply/divide engine, with stall for MDU ops while busy.
module ula_control_md
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ula_operation,
  input  logic [5:0]       func,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       operation,
  output logic [WIDTH-1:0] hilo_data,
  output logic             stall,
  output logic             done
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, hi_res, lo_res;
  logic busy, is_r, idle_req, start_mul, start_div, is_signed;
  always_comb begin
    operation = OP_AND;
    if (ula_operation == UOP_BR) operation = OP_SUB;
    else if (ula_operation != UOP_R) operation = OP_ADD;
    else
      case (func)
        F_ADD:   operation = OP_ADD;
        F_SUB:   operation = OP_SUB;
        F_AND:   operation = OP_AND;
        F_OR:    operation = OP_OR;
        F_XOR:   operation = OP_XOR;
        F_NOR:   operation = OP_NOR;
        F_SLT:   operation = OP_SLT;
        F_SLL:   operation = OP_SLL;
        F_SRL:   operation = OP_SRL;
        F_SRA:   operation = OP_SRA;
        default: operation = OP_AND;
      endcase
  end
  always_comb begin
    is_r      = ula_operation == UOP_R;
    idle_req  = valid && is_r && !busy;
    start_mul = idle_req && (func == F_MULT || func == F_MULTU);
    start_div = idle_req && (func == F_DIV || func == F_DIVU);
    is_signed = func == F_MULT || func == F_DIV;
    stall     = valid && busy && is_r && is_mdu_func(func);
    hi_d      = done ? hi_res : (idle_req && func == F_MTHI) ? a : hi_q;
    lo_d      = done ? lo_res : (idle_req && func == F_MTLO) ? a : lo_q;
    hilo_data = (is_r && func == F_MFHI) ? hi_q : lo_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  ula_mdu #(.WIDTH(WIDTH), .CW(CW)) u_mdu (
    .clk       (clk),
    .rst       (rst),
    .start_mul (start_mul),
    .start_div (start_div),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi_res    (hi_res),
    .lo_res    (lo_res)
  );
endmodule

// File: doc/ula_control_md.md
ULA_CONTROL_MD -- requirements
Module: ula_control_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands, HI and LO.
REQ-002 Parameter CW, default $clog2(WIDTH), iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ula_operation  input  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 immediate add.
REQ-006 func  input  6  R-type function field.
REQ-007 valid  input  1  instruction present this cycle.
REQ-008 a  input  WIDTH  rs operand.
REQ-009 b  input  WIDTH  rt operand.
REQ-010 operation  output  4  ALU operation code.
REQ-011 hilo_data  output  WIDTH  HI for mfhi, LO otherwise.
REQ-012 stall  output  1  hold the current instruction.
REQ-013 done  output  1  multiply/divide completion pulse.

Function
REQ-014 Decode SHALL be combinational: 00->0010; 01->0110; 11->0010; 10 by func: add 100000->0010, sub 100010->0110, and 100100->0000, or 100101->0001, xor 100110->1101, nor 100111->1100, slt 101010->0111, sll 000000->0011, srl 000010->0100, sra 000011->0101, others->0000.
REQ-015 MDU functions (ula_operation 10): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-016 FSM states IDLE, MUL, DIV, FIN; busy = state != IDLE.
REQ-017 In IDLE, valid mult/multu SHALL latch a, b and go MUL; valid div/divu SHALL go DIV, at the same edge.
REQ-018 Signed ops SHALL iterate on magnitudes and record result signs; unsigned ops use raw values.
REQ-019 MUL: shift-add, one bit per cycle, exactly WIDTH cycles, then FIN.
REQ-020 DIV: restoring, one quotient bit per cycle, exactly WIDTH cycles, then FIN.
REQ-021 FIN lasts one cycle: sign correction applied (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); HI/LO written at the FIN->IDLE edge.
REQ-022 Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
REQ-023 Divide: LO = quotient, HI = remainder.
REQ-024 Divisor zero SHALL give HI = a, LO = all ones, for both signednesses.
REQ-025 Signed minimum / -1 SHALL give LO = minimum, HI = 0.
REQ-026 done SHALL be 1 exactly during FIN, else 0.
REQ-027 stall = valid and busy and func is any REQ-015 code with ula_operation 10; non-MDU instructions SHALL never stall.
REQ-028 MDU start requests while busy SHALL be ignored (held by stall).
REQ-029 mthi/mtlo in IDLE SHALL write a to HI/LO at the next edge, single cycle, no stall.
REQ-030 mfhi/mflo in IDLE SHALL return current HI/LO combinationally; result latency start-edge to HI/LO visible is WIDTH+2 edges.

Reset
REQ-031 rst asserted SHALL immediately force state IDLE, counter 0, HI 0, LO 0, latched operands 0, done 0, stall 0, independent of clk.
REQ-032 Reset mid-MUL/DIV SHALL abandon the operation without HI/LO update; first valid start after release SHALL complete normally.

Structure
REQ-033 Shared package ula_pkg SHALL hold the 4-bit operation codes, func codes, ula_operation codes and FSM state type.
REQ-034 Iterative engine (FSM, counter, operand/accumulator registers, sign correction) SHALL be sub-module ula_mdu; decode and HI/LO registers stay in ula_control_md.

Verification (WIDTH=32)
REQ-035 Decode sweep: ula_operation 10/func 101010 -> 0111; 000011 -> 0101; ula_operation 01 -> 0110; 10/func 111111 -> 0000.
REQ-036 mult a=0xFFFFFFFD b=7 -> after 34 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; done one cycle; mflo issued while busy stalls until IDLE, then returns 0xFFFFFFEB.
REQ-037 divu 100/7 -> LO=14, HI=2; div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 div 5/0 -> HI=5, LO=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 add issued during DIV -> operation 0010, stall 0; mthi during DIV stalls, then HI=a one edge after IDLE.
REQ-040 rst pulsed at MUL cycle 10 -> IDLE, HI=LO=0, done=0 immediately; next multu 6*7 -> LO=42, HI=0.
